dp_sequencer: RTL and testbench
===============================

DP_SEQUENCER -- requirements
Module: dp_sequencer

Interface
REQ-001 The block SHALL have parameter PC_RESET, default 32'h0000_0000, giving the first fetch address after start.
REQ-002 The block SHALL have parameter PC_STEP, default 4, giving the PC increment per retired instruction.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: begins execution from IDLE.
REQ-006 The block SHALL have port imem_req, output, 1 bit: instruction-memory request.
REQ-007 The block SHALL have port imem_addr, output, 32 bits: fetch address, equal to PC.
REQ-008 The block SHALL have port imem_ack, input, 1 bit: instruction-memory acknowledge, with data valid.
REQ-009 The block SHALL have port imem_data, input, 32 bits: fetched instruction word.
REQ-010 The block SHALL have port instr, output, 32 bits: latched instruction driving the datapath instruction bus.
REQ-011 The block SHALL have port reg_wr_en, output, 1 bit: register-file write strobe.
REQ-012 The block SHALL have port mem_wr_en, output, 1 bit: data-memory write strobe.
REQ-013 The block SHALL have port mem_to_reg, output, 1 bit: write-back mux select (1 = memory data, 0 = ALU result).
REQ-014 The block SHALL have port busy, output, 1 bit: high in any state except IDLE and HALT.
REQ-015 The block SHALL have port halted, output, 1 bit: high in HALT.
REQ-016 The block SHALL have port retired, output, 16 bits: count of retired instructions.

Function
REQ-017 The block SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-018 In IDLE, the block SHALL move to FETCH on the first rising edge that samples start=1, with PC = PC_RESET.
REQ-019 In FETCH, imem_req SHALL be 1 and imem_addr SHALL hold PC stable until an edge samples imem_ack=1.
REQ-020 On the edge that samples imem_ack=1 in FETCH, instr SHALL load imem_data and the state SHALL move to DECODE.
REQ-021 imem_ack SHALL be ignored in every state other than FETCH.
REQ-022 DECODE SHALL last 1 cycle and SHALL classify instr[31:26]: 000000 R-type; 100011 lw; 101011 sw; 111111 halt; any other value illegal.
REQ-023 After DECODE, a halt opcode SHALL go to HALT, an illegal opcode SHALL go to FETCH at PC+PC_STEP with no writes and no retire, and any other opcode SHALL go to EXEC.
REQ-024 EXEC SHALL last 1 cycle, with the ALU settling; R-type then goes to WB, and lw/sw then go to MEM.
REQ-025 MEM SHALL last 1 cycle; mem_wr_en SHALL be 1 in MEM only for sw; lw then goes to WB and sw retires.
REQ-026 WB SHALL last 1 cycle; reg_wr_en SHALL be 1 in WB; mem_to_reg SHALL be 1 in WB only for lw.
REQ-027 Strobes (reg_wr_en, mem_wr_en, mem_to_reg) SHALL be 0 in all other states and SHALL be exactly one cycle wide per instruction.
REQ-028 On retire (leaving WB, or leaving MEM for sw), PC SHALL become PC+PC_STEP modulo 2^32, retired SHALL increment, and the state SHALL go to FETCH.
REQ-029 retired SHALL wrap from 16'hFFFF to 16'h0000.
REQ-030 With imem_ack=1 on the first FETCH cycle, latency from FETCH entry to retire SHALL be 4 cycles for R-type and sw, and 5 cycles for lw.
REQ-031 instr SHALL remain stable from DECODE through retire.
REQ-032 start SHALL be ignored outside IDLE.
REQ-033 HALT SHALL be exited only by rst, and the halt instruction SHALL NOT increment retired.

Reset
REQ-034 While rst=1, asynchronously: state IDLE, PC=PC_RESET, instr=0, imem_req=0, imem_addr=PC_RESET, reg_wr_en=0, mem_wr_en=0, mem_to_reg=0, busy=0, halted=0, retired=0.
REQ-035 rst asserted mid-instruction SHALL abort the instruction: no strobe is issued after rst rises, an outstanding request is dropped, and no retire is counted.
REQ-036 After rst falls, the block SHALL wait in IDLE for start.

Verification
REQ-037 The bench SHALL cover: start with immediate ack and imem_data=32'h0001_1020 (add) -> reg_wr_en=1 exactly in cycle 4 after FETCH entry, mem_to_reg=0, retired=1, imem_addr=4.
REQ-038 The bench SHALL cover: lw 32'h8C22_0000 with ack delayed 3 cycles -> imem_req held 4 cycles with imem_addr=0 stable, then reg_wr_en=1 with mem_to_reg=1 in WB, and retire 5 cycles after ack.
REQ-039 The bench SHALL cover: sw 32'hAC22_0000 -> one mem_wr_en pulse, reg_wr_en never asserted, next FETCH at addr 4.
REQ-040 The bench SHALL cover: opcode 6'b010101 then halt 32'hFC00_0000 -> no strobes, illegal op skipped (addr 4 fetched), halted=1, busy=0, retired=0, and start pulse ignored.
REQ-041 The bench SHALL cover: rst pulsed during EXEC of an add -> outputs at reset values immediately, no reg_wr_en, retired=0, and a restart fetches PC_RESET.
REQ-042 The bench SHALL cover: retired preloaded by 65535 R-type retirements -> the next retire gives retired=16'h0000.

Source files
------------

// File: rtl/dp_sequencer.sv
// Multi-cycle control sequencer: fetches an instruction word, classifies its opcode
// and walks it through DECODE/EXEC/MEM/WB while issuing one-cycle datapath strobes.
module dp_sequencer #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic        reg_wr_en,
    output logic        mem_wr_en,
    output logic        mem_to_reg,
    output logic        busy,
    output logic        halted,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
    } state_t;

    typedef enum logic [1:0] {
        OP_R, OP_LW, OP_SW
    } kind_t;

    localparam logic [5:0] OPC_R    = 6'b000000;
    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;
    localparam logic [5:0] OPC_HALT = 6'b111111;

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [15:0] retired_q, retired_d;
    logic        imem_req_q, imem_req_d;
    logic        reg_wr_en_q, reg_wr_en_d;
    logic        mem_wr_en_q, mem_wr_en_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic        busy_q, busy_d;
    logic        halted_q, halted_d;

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = PC_RESET;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_data;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                case (instr_q[31:26])
                    OPC_R: begin
                        kind_d  = OP_R;
                        state_d = EXEC;
                    end
                    OPC_LW: begin
                        kind_d  = OP_LW;
                        state_d = EXEC;
                    end
                    OPC_SW: begin
                        kind_d  = OP_SW;
                        state_d = EXEC;
                    end
                    OPC_HALT: state_d = HALT;
                    // Illegal opcodes are skipped silently: no strobes, no retire.
                    default: begin
                        pc_d    = pc_q + PC_STEP;
                        state_d = FETCH;
                    end
                endcase
            end
            EXEC: state_d = (kind_q == OP_R) ? WB : MEM;
            MEM: begin
                if (kind_q == OP_SW) begin
                    pc_d      = pc_q + PC_STEP;
                    retired_d = retired_q + 16'd1;
                    state_d   = FETCH;
                end else begin
                    state_d = WB;
                end
            end
            WB: begin
                pc_d      = pc_q + PC_STEP;
                retired_d = retired_q + 16'd1;
                state_d   = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered yet cycle-aligned.
        imem_req_d   = (state_d == FETCH);
        reg_wr_en_d  = (state_d == WB);
        mem_wr_en_d  = (state_d == MEM) && (kind_d == OP_SW);
        mem_to_reg_d = (state_d == WB) && (kind_d == OP_LW);
        busy_d       = (state_d != IDLE) && (state_d != HALT);
        halted_d     = (state_d == HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            kind_q       <= OP_R;
            pc_q         <= PC_RESET;
            instr_q      <= 32'h0;
            retired_q    <= 16'h0;
            imem_req_q   <= 1'b0;
            reg_wr_en_q  <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            retired_q    <= retired_d;
            imem_req_q   <= imem_req_d;
            reg_wr_en_q  <= reg_wr_en_d;
            mem_wr_en_q  <= mem_wr_en_d;
            mem_to_reg_q <= mem_to_reg_d;
            busy_q       <= busy_d;
            halted_q     <= halted_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign instr      = instr_q;
    assign reg_wr_en  = reg_wr_en_q;
    assign mem_wr_en  = mem_wr_en_q;
    assign mem_to_reg = mem_to_reg_q;
    assign busy       = busy_q;
    assign halted     = halted_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed bench for dp_sequencer: each instruction pushes its predicted strobe
// timing onto a scoreboard, which is popped and compared once the instruction completes.
module tb_dp_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic        reg_wr_en;
    logic        mem_wr_en;
    logic        mem_to_reg;
    logic        busy;
    logic        halted;
    logic [15:0] retired;

    int tests_run  = 0;
    int fail_count = 0;

    logic [31:0] model_pc;
    logic [15:0] model_retired;

    typedef struct {
        int          reg_pulses;
        int          mem_pulses;
        logic        m2r;
        int          reg_cycle;
        int          mem_cycle;
        int          end_cycle;
        logic [15:0] retired;
        logic [31:0] next_addr;
        logic        halted;
    } exp_t;

    exp_t scoreboard[$];

    dp_sequencer #(.PC_RESET(32'h0000_0000), .PC_STEP(32'd4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .instr      (instr),
        .reg_wr_en  (reg_wr_en),
        .mem_wr_en  (mem_wr_en),
        .mem_to_reg (mem_to_reg),
        .busy       (busy),
        .halted     (halted),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drives rst/start for one cycle starting at a falling edge.
    task automatic applyStimulus(input logic rst_v, input logic start_v);
        @(negedge clk);
        rst   = rst_v;
        start = start_v;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " imem_req"},   imem_req,   0);
        checkOutput({tag, " imem_addr"},  imem_addr,  32'h0);
        checkOutput({tag, " instr"},      instr,      32'h0);
        checkOutput({tag, " reg_wr_en"},  reg_wr_en,  0);
        checkOutput({tag, " mem_wr_en"},  mem_wr_en,  0);
        checkOutput({tag, " mem_to_reg"}, mem_to_reg, 0);
        checkOutput({tag, " busy"},       busy,       0);
        checkOutput({tag, " halted"},     halted,     0);
        checkOutput({tag, " retired"},    {16'h0, retired}, 32'h0);
    endtask

    // Cycle 1 is the first FETCH cycle; timing follows the per-opcode latencies.
    function automatic exp_t expectFor(input logic [31:0] word, input int delay);
        exp_t e;
        e.reg_pulses = 0;
        e.mem_pulses = 0;
        e.m2r        = 1'b0;
        e.reg_cycle  = 0;
        e.mem_cycle  = 0;
        e.retired    = model_retired;
        e.next_addr  = model_pc;
        e.halted     = 1'b0;
        case (word[31:26])
            6'b000000: begin
                e.reg_pulses = 1; e.reg_cycle = delay + 4; e.end_cycle = delay + 5;
                e.retired = model_retired + 16'd1; e.next_addr = model_pc + 32'd4;
            end
            6'b100011: begin
                e.reg_pulses = 1; e.reg_cycle = delay + 5; e.end_cycle = delay + 6; e.m2r = 1'b1;
                e.retired = model_retired + 16'd1; e.next_addr = model_pc + 32'd4;
            end
            6'b101011: begin
                e.mem_pulses = 1; e.mem_cycle = delay + 4; e.end_cycle = delay + 5;
                e.retired = model_retired + 16'd1; e.next_addr = model_pc + 32'd4;
            end
            6'b111111: begin
                e.end_cycle = delay + 3; e.halted = 1'b1;
            end
            default: begin
                e.end_cycle = delay + 3; e.next_addr = model_pc + 32'd4;
            end
        endcase
        return e;
    endfunction

    // Entered at a falling edge with the DUT in its first FETCH cycle.
    task automatic execInstr(input string tag, input logic [31:0] word, input int delay);
        exp_t e;
        int   cyc = 1;
        int   fetch_cycles = 0, reg_p = 0, mem_p = 0, reg_c = 0, mem_c = 0, stray_m2r = 0;
        logic m2r = 1'b0, addr_ok = 1'b1, instr_ok = 1'b1, busy_ok = 1'b1, done = 1'b0;

        scoreboard.push_back(expectFor(word, delay));

        while (cyc <= delay + 1) begin
            if (imem_req !== 1'b1 || imem_addr !== model_pc) addr_ok = 1'b0;
            if (imem_req === 1'b1) fetch_cycles++;
            imem_ack  = (cyc == delay + 1);
            imem_data = imem_ack ? word : $urandom;
            @(negedge clk);
            cyc++;
        end
        imem_ack  = 1'b1;
        imem_data = 32'hDEAD_BEEF;

        while (!done && cyc < 40) begin
            if (reg_wr_en === 1'b1) begin reg_p++; reg_c = cyc; m2r = mem_to_reg; end
            if (mem_wr_en === 1'b1) begin mem_p++; mem_c = cyc; end
            if (mem_to_reg === 1'b1 && reg_wr_en !== 1'b1) stray_m2r++;
            if (instr !== word) instr_ok = 1'b0;
            if (imem_req === 1'b1 || halted === 1'b1) begin
                done = 1'b1;
            end else begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                @(negedge clk);
                cyc++;
            end
        end
        imem_ack  = 1'b0;
        imem_data = 32'h0;

        e = scoreboard.pop_front();
        checkOutput({tag, " completed"},    done,         1);
        checkOutput({tag, " fetch_cycles"}, fetch_cycles, delay + 1);
        checkOutput({tag, " addr_stable"},  addr_ok,      1);
        checkOutput({tag, " instr_stable"}, instr_ok,     1);
        checkOutput({tag, " busy_held"},    busy_ok,      1);
        checkOutput({tag, " reg_pulses"},   reg_p,        e.reg_pulses);
        checkOutput({tag, " reg_cycle"},    reg_c,        e.reg_cycle);
        checkOutput({tag, " mem_to_reg"},   m2r,          e.m2r);
        checkOutput({tag, " stray_m2r"},    stray_m2r,    0);
        checkOutput({tag, " mem_pulses"},   mem_p,        e.mem_pulses);
        checkOutput({tag, " mem_cycle"},    mem_c,        e.mem_cycle);
        checkOutput({tag, " end_cycle"},    cyc,          e.end_cycle);
        checkOutput({tag, " retired"},      {16'h0, retired}, {16'h0, e.retired});
        checkOutput({tag, " halted"},       halted,       e.halted);
        checkOutput({tag, " busy_end"},     busy,         !e.halted);
        if (!e.halted) checkOutput({tag, " next_addr"}, imem_addr, e.next_addr);
        model_pc      = e.next_addr;
        model_retired = e.retired;
    endtask

    initial begin
        int   strobe_after_rst;
        logic idle_ok;

        rst       = 1'b1;
        start     = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 32'h0;
        model_pc      = 32'h0;
        model_retired = 16'h0;
        repeat (2) @(negedge clk);
        checkResetValues("reset");

        rst = 1'b0;
        idle_ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (imem_req !== 1'b0 || busy !== 1'b0) idle_ok = 1'b0;
        end
        checkOutput("idle_waits_for_start", idle_ok, 1);

        applyStimulus(1'b0, 1'b1);
        checkOutput("start_enters_fetch", imem_req, 1);
        execInstr("add", 32'h0001_1020, 0);
        execInstr("lw_delayed", 32'h8C22_0000, 3);
        start = 1'b1;
        execInstr("sw_start_held", 32'hAC22_0000, 0);
        start = 1'b0;

        $display("[TB] illegal opcode then halt");
        applyStimulus(1'b1, 1'b0);
        rst = 1'b0;
        model_pc = 32'h0; model_retired = 16'h0;
        applyStimulus(1'b0, 1'b1);
        execInstr("illegal", 32'h5400_0000, 0);
        execInstr("halt", 32'hFC00_0000, 0);
        applyStimulus(1'b0, 1'b1);
        @(negedge clk);
        checkOutput("halt_ignores_start_halted", halted, 1);
        checkOutput("halt_ignores_start_req",    imem_req, 0);
        checkOutput("halt_ignores_start_busy",   busy, 0);

        $display("[TB] reset during EXEC");
        applyStimulus(1'b1, 1'b0);
        rst = 1'b0;
        model_pc = 32'h0; model_retired = 16'h0;
        applyStimulus(1'b0, 1'b1);
        imem_ack  = 1'b1;
        imem_data = 32'h0001_1020;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        checkOutput("exec_before_abort_busy", busy, 1);
        rst = 1'b1;
        #1;
        checkResetValues("abort");
        strobe_after_rst = 0;
        repeat (3) begin
            @(negedge clk);
            if (reg_wr_en !== 1'b0 || mem_wr_en !== 1'b0) strobe_after_rst++;
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (reg_wr_en !== 1'b0 || imem_req !== 1'b0) strobe_after_rst++;
        end
        checkOutput("abort_no_strobe", strobe_after_rst, 0);
        checkOutput("abort_retired",   {16'h0, retired}, 32'h0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("restart_addr", imem_addr, 32'h0);
        execInstr("add_after_abort", 32'h0001_1020, 0);

        $display("[TB] retired counter wrap");
        force dut.retired_q = 16'hFFFE;
        #1;
        release dut.retired_q;
        model_retired = 16'hFFFE;
        execInstr("add_to_ffff", 32'h0002_2820, 0);
        execInstr("add_wrap",    32'h0003_3020, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
